// File: rtl/keypad_pkg.sv
// Shared constants, scan-state encoding and key numbering
// for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic {
    DRIVE,
    EVAL
  } scan_state_e;

  function automatic logic [3:0] key_index(
    input int row,
    input int col
  );
    return 4'(row * NUM_COLS + col);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines and debounced key-state outputs.
// master = keypad/consumer side, slave = scanner.
interface keypad_scanner_if;

  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;
  logic        key_event;
  logic        frame_done;
  logic        ghost;

  modport master (
    output row_in,
    input  col_out,
    input  keys,
    input  key_event,
    input  frame_done,
    input  ghost
  );

  modport slave (
    input  row_in,
    output col_out,
    output keys,
    output key_event,
    output frame_done,
    output ghost
  );

endinterface

// File: rtl/key_debounce.sv
// One key: flips its state after DEBOUNCE_FRAMES consecutive
// disagreeing frames; any agreeing frame clears the run.
module key_debounce #(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic update,
  input  logic frame_bit,
  output logic key,
  output logic flip
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic          differ;

  assign differ = frame_bit ^ key;
  assign flip   = update & differ & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      key <= 1'b0;
    end else if (update) begin
      if (!differ || flip)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (flip)
        key <= ~key;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sync, per-key debounce.
// Optional rectangle (ghost) rejection: KEYPAD_GHOST_REJECT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input logic             clk,
  input logic             rst,
  keypad_scanner_if.slave bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  scan_state_e   state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [DW-1:0] div_q, div_d;
  logic [15:0]   raw_q, raw_d;
  logic [3:0]    row_s1, row_s2;
  logic          eval;
  logic          upd;
  logic [15:0]   key_st;
  logic [15:0]   flip;
  logic          key_event_q;
  logic          frame_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= bus.row_in;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DRIVE;
      col_q   <= 2'd0;
      div_q   <= '0;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      div_q   <= div_d;
      raw_q   <= raw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    raw_d   = raw_q;
    eval    = 1'b0;
    unique case (state_q)
      DRIVE: begin
        if (div_q == DIV_LAST) begin
          for (int r = 0; r < NUM_ROWS; r++)
            raw_d[key_index(r, int'(col_q))] = ~row_s2[r];
          div_d = '0;
          if (col_q == 2'd3) begin
            // column 0 is driven again during EVAL
            col_d   = 2'd0;
            state_d = EVAL;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      EVAL: begin
        eval    = 1'b1;
        div_d   = '0;
        state_d = DRIVE;
      end
      default: state_d = DRIVE;
    endcase
  end

`ifdef KEYPAD_GHOST_REJECT_EN
  logic rect;
  logic ghost_q;

  function automatic logic has_rect(input logic [15:0] f);
    logic [2:0] n;
    has_rect = 1'b0;
    for (int a = 0; a < NUM_COLS; a++) begin
      for (int b = a + 1; b < NUM_COLS; b++) begin
        n = '0;
        for (int r = 0; r < NUM_ROWS; r++)
          n = n + 3'(f[key_index(r, a)] & f[key_index(r, b)]);
        if (n >= 3'd2)
          has_rect = 1'b1;
      end
    end
  endfunction

  assign rect      = has_rect(raw_q);
  assign upd       = eval & ~rect;
  assign bus.ghost = ghost_q;

  always_ff @(posedge clk) begin
    if (rst)
      ghost_q <= 1'b0;
    else
      ghost_q <= eval & rect;
  end
`else
  assign upd       = eval;
  assign bus.ghost = 1'b0;
`endif

  for (genvar k = 0; k < 16; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .update   (upd),
      .frame_bit(raw_q[k]),
      .key      (key_st[k]),
      .flip     (flip[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_event_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      key_event_q  <= upd & (|flip);
      frame_done_q <= eval;
    end
  end

  assign bus.col_out    = ~(4'b0001 << col_q);
  assign bus.keys       = key_st;
  assign bus.key_event  = key_event_q;
  assign bus.frame_done = frame_done_q;

endmodule
